// File: rtl/queue_rr_sched.sv
// Round-robin dequeue scheduler: grants one eligible queue per cycle under a
// 2-credit limit, captures the 1-cycle-latency RAM read data and presents it
// downstream through a 2-entry in-order buffer tagged with the queue id.
module queue_rr_sched #(
    parameter int unsigned Q = 4,
    parameter int unsigned W = 32
) (
    input  logic                     clk,
    input  logic                     arst_n,
    input  logic [Q-1:0]             i_empty,
    input  logic [Q-1:0]             i_mask,
    output logic [Q-1:0]             o_pop,
    input  logic [Q*W-1:0]           i_rdata,
    output logic                     o_valid,
    output logic [W-1:0]             o_data,
    output logic [$clog2(Q)-1:0]     o_qid,
    input  logic                     i_ready
);

    localparam int unsigned QID_W = $clog2(Q);

    typedef struct packed {
        logic [QID_W-1:0] qid;
        logic [W-1:0]     data;
    } entry_t;

    logic [Q-1:0]     elig;
    logic [QID_W-1:0] ptr;
    logic [QID_W-1:0] ptr_nxt;
    logic [QID_W-1:0] gnt;
    logic             gnt_vld;
    logic [QID_W-1:0] cand;
    logic [31:0]      idx;
    logic             infl;
    logic [QID_W-1:0] qid_r;
    logic [1:0]       occ;
    logic [2:0]       credit;
    logic             issue_ok;
    logic             hs;
    logic             wr;
    logic             rd_idx;
    logic             wr_idx;
    entry_t           buf_q [2];

    assign elig = ~i_empty & i_mask;
    assign hs   = o_valid & i_ready;
    assign wr   = infl;

    // Credit check: buffered + in-flight entries, minus the one leaving now
    always_comb begin
        credit   = 3'(occ) + 3'(infl) - 3'(hs);
        issue_ok = (credit < 3'd2);
    end

    // Rotating-priority scan starting at ptr; suppressed while in reset
    always_comb begin
        gnt     = '0;
        gnt_vld = 1'b0;
        idx     = '0;
        cand    = '0;
        for (int unsigned i = 0; i < Q; i++) begin
            idx = 32'(ptr) + i;
            if (idx >= Q) begin
                idx = idx - Q;
            end
            cand = QID_W'(idx);
            if (!gnt_vld && elig[cand]) begin
                gnt_vld = 1'b1;
                gnt     = cand;
            end
        end
        if (!issue_ok || !arst_n) begin
            gnt_vld = 1'b0;
        end
    end

    // One-hot pop strobe and next pointer
    always_comb begin
        o_pop   = '0;
        ptr_nxt = ptr;
        if (gnt_vld) begin
            o_pop[gnt] = 1'b1;
            ptr_nxt    = (gnt == QID_W'(Q - 1)) ? '0 : gnt + QID_W'(1);
        end
    end

    // Pointer and read-pipeline tracking
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            ptr   <= '0;
            infl  <= 1'b0;
            qid_r <= '0;
        end else begin
            ptr  <= ptr_nxt;
            infl <= gnt_vld;
            if (gnt_vld) begin
                qid_r <= gnt;
            end
        end
    end

    // Output buffer: capture returned read data, retire on handshake
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            buf_q[0] <= '0;
            buf_q[1] <= '0;
            rd_idx   <= 1'b0;
            wr_idx   <= 1'b0;
            occ      <= '0;
        end else begin
            if (wr) begin
                buf_q[wr_idx].data <= i_rdata[32'(qid_r)*W +: W];
                buf_q[wr_idx].qid  <= qid_r;
                wr_idx             <= ~wr_idx;
            end
            if (hs) begin
                rd_idx <= ~rd_idx;
            end
            occ <= occ + 2'(wr) - 2'(hs);
        end
    end

    // Head entry presented downstream
    always_comb begin
        o_valid = (occ != 2'd0);
        o_data  = buf_q[rd_idx].data;
        o_qid   = buf_q[rd_idx].qid;
    end

endmodule

// File: doc/queue_rr_sched.md
Name: queue_rr_sched

Overview:
- Round-robin dequeue scheduler for Q independent queues, each built from a queue controller plus a 1-cycle-latency read RAM.
- Picks one non-empty, enabled queue per cycle and issues its pop. It captures the returned read data and presents it downstream on a valid/ready interface, tagged with the queue id.
- Credit-limited so in-flight reads never overflow the internal 2-entry output buffer.
- Sits between the per-queue storage and a single shared downstream consumer.

Parameters:
- Q, 4, number of queues; Q >= 2; need not be a power of 2.
- W, 32, data width per queue entry.
- QID_W, $clog2(Q), queue id width (derived).

Ports:
- clk  input  1  clock
- arst_n  input  1  asynchronous active-low reset
- i_empty  input  Q  per-queue registered empty status for the current cycle; bit q=1 means queue q is empty
- i_mask  input  Q  per-queue enable; bit q=0 means queue q is never granted
- o_pop  output  Q  one-hot pop strobe to queue q; its RAM read address is sampled this cycle
- i_rdata  input  Q*W  flattened RAM read data; slice q is valid the cycle after o_pop[q]
- o_valid  output  1  output buffer non-empty
- o_data  output  W  head entry data
- o_qid  output  QID_W  head entry queue id
- i_ready  input  1  downstream accept; a handshake occurs when o_valid & i_ready

Behaviour:
- Reset (async assert, sync-safe deassert):
  - o_pop=0, o_valid=0, o_data=0, o_qid=0.
  - RR pointer=0, in-flight flag=0, buffer occupancy=0.
  - A reset mid-operation drops in-flight reads and buffered entries with no replay.
- Eligibility: elig = ~i_empty & i_mask.
- Credit rule:
  - Issue is allowed iff (occ + infl - (o_valid & i_ready)) < 2.
  - occ is in 0..2; infl is 0/1 (pop issued last cycle).
- Arbitration:
  - If issue is allowed and elig != 0, grant the first eligible q scanning ptr, ptr+1, ..., Q-1, 0, ..., ptr-1.
  - o_pop = onehot(g) in the same cycle (combinational from state, i_empty, i_mask, i_ready).
  - Next ptr = (g == Q-1) ? 0 : g+1.
  - No grant: o_pop=0 and ptr holds.
  - At most one o_pop bit is set per cycle.
- Read pipeline:
  - Pop at cycle t registers infl=1 and qid_r=g at the end of t.
  - In cycle t+1, i_rdata[qid_r*W +: W] and qid_r are written into the buffer at the end of t+1.
  - o_valid rises in t+2: pop-to-valid latency is 2 cycles.
- Output buffer:
  - 2-entry FIFO, in order; o_data/o_qid show the head entry.
  - Simultaneous write and read is allowed at any occupancy; a write at occ=2 is impossible by the credit rule.
  - o_data/o_qid hold steady while o_valid & ~i_ready.
- Throughput: with i_ready held at 1, one pop and one output per cycle sustained (steady state occ=1, infl=1).
- Backpressure: with i_ready=0, at most 2 pops are issued in total before o_pop stays 0.
- Empty status:
  - The block never pops a queue whose i_empty bit is 1.
  - The queue owner updates i_empty by the next cycle. A queue holding 1 entry is popped once and then shows empty.
- Mask changes take effect the same cycle and do not move ptr.
- The block adds no flops on i_rdata; it relies on the RAM holding data for the cycle after the pop.

Test Plan:
- Reset: assert arst_n=0 mid-stream -> o_pop=0, o_valid=0, o_qid=0 immediately. After release, all queues non-empty with i_ready=1 -> first grant is queue 0.
- Q=4, i_mask=4'b1111, i_empty=4'b1010 (queues 0,2 non-empty), i_ready=1:
  - o_pop = 0001, 0100, 0001, 0100, ...
  - o_qid sequence 0,2,0,2 starting 2 cycles after the first pop.
  - o_data equals the matching i_rdata slice.
- Backpressure, all queues non-empty, i_ready=0:
  - Pops only to q0 then q1, then o_pop=0.
  - o_valid=1 with o_qid=0 held stable.
  - Raise i_ready -> outputs qid 0,1 with no gap, next pop goes to q2.
- Mask: i_mask=4'b1011, all non-empty, i_ready=1 -> grant sequence 0,1,3,0,1,3; queue 2 never popped.
- Wrap/ptr:
  - Only q3 eligible -> pop q3, ptr=0.
  - Next cycle q0 and q3 eligible -> grant q0, then q3.
  - Then no queue eligible for 3 cycles -> o_pop=0 and the next grant follows ptr=0 order.
- Reset with pop in flight: pop q1 at t, assert arst_n=0 at t+1 -> no output is ever produced for that pop; o_valid stays 0 after release until a new pop.
